// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - control and status bundle for the divided-clock monitor
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic             stuck;
    logic [7:0]       err_count;

    modport master (
        output en, div_in,
        input  rise_pulse, fall_pulse, half_period, period_valid,
               locked, err, stuck, err_count
    );

    modport slave (
        input  en, div_in,
        output rise_pulse, fall_pulse, half_period, period_valid,
               locked, err, stuck, err_count
    );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures div_in edge spacing in clk cycles and tracks lock
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_HALF   = 4,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    clk_div_monitor_if.slave  mon
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP_X     = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);

    state_t           state_q, state_d;
    logic             div_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic             edge_w;
    logic [CNT_W-1:0] measured;
    logic [CNT_W:0]   meas_x;
    logic [CNT_W:0]   diff_x;
    logic             in_tol;

    assign edge_w   = mon.div_in ^ div_q;
    assign measured = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_ONE;
    // One extra bit keeps the absolute difference from wrapping.
    assign meas_x   = {1'b0, measured};
    assign diff_x   = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
    assign in_tol   = (diff_x <= TOL_X);

    always_comb begin
        state_d        = state_q;
        run_cnt_d      = run_cnt_q;
        match_cnt_d    = match_cnt_q;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        err_d          = 1'b0;
        stuck_d        = stuck_q;
        err_count_d    = err_count_q;
        rise_d         = 1'b0;
        fall_d         = 1'b0;

        if (!mon.en) begin
            state_d     = SEARCH;
            run_cnt_d   = '0;
            match_cnt_d = '0;
            stuck_d     = 1'b0;
        end else begin
            rise_d    = edge_w & mon.div_in;
            fall_d    = edge_w & ~mon.div_in;
            run_cnt_d = edge_w ? '0 : ((run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE);

            case (state_q)
                SEARCH: begin
                    if (edge_w) begin
                        state_d     = MEASURE;
                        stuck_d     = 1'b0;
                        match_cnt_d = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    // An edge coinciding with the timeout count wins over the timeout.
                    if (edge_w) begin
                        half_period_d  = measured;
                        period_valid_d = 1'b1;
                        if (in_tol) begin
                            if (state_q == MEASURE) begin
                                if (match_cnt_q == LOCK_LAST) begin
                                    state_d     = LOCKED;
                                    match_cnt_d = match_cnt_q + 4'd1;
                                end else begin
                                    match_cnt_d = match_cnt_q + 4'd1;
                                end
                            end
                        end else begin
                            state_d     = MEASURE;
                            match_cnt_d = '0;
                            err_d       = 1'b1;
                        end
                    end else if (run_cnt_q == TO_LAST) begin
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                        stuck_d     = 1'b1;
                        err_d       = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SEARCH;
            div_q          <= 1'b0;
            run_cnt_q      <= '0;
            match_cnt_q    <= '0;
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            stuck_q        <= 1'b0;
            err_count_q    <= '0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= mon.div_in;
            run_cnt_q      <= run_cnt_d;
            match_cnt_q    <= match_cnt_d;
            half_period_q  <= half_period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
            stuck_q        <= stuck_d;
            err_count_q    <= err_count_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
        end
    end

    assign mon.rise_pulse   = rise_q;
    assign mon.fall_pulse   = fall_q;
    assign mon.half_period  = half_period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.err          = err_q;
    assign mon.stuck        = stuck_q;
    assign mon.err_count    = err_count_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - scoreboard bench for clk_div_monitor with TOL=0 and TOL=1 instances
module tb_clk_div_monitor;
    localparam int EXP_HALF   = 4;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 16;
    localparam int P_SEARCH   = 0;
    localparam int P_MEASURE  = 1;
    localparam int P_LOCKED   = 2;

    typedef struct packed {
        logic       pv;
        logic [7:0] half;
        logic       locked;
        logic       err;
        logic [7:0] ecnt;
        logic       stuck;
    } ev_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic en_r  = 1'b1;
    logic div_r = 1'b0;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int last_edge = 0;
    int n_rise = 0, n_fall = 0, m_rise = 0, m_fall = 0;

    int phase [2];
    int match [2];
    int ecnt  [2];
    int half  [2];
    int tol   [2];

    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_div_monitor_if #(.CNT_W(8)) if0 ();
    clk_div_monitor_if #(.CNT_W(8)) if1 ();

    assign if0.en     = en_r;
    assign if0.div_in = div_r;
    assign if1.en     = en_r;
    assign if1.div_in = div_r;

    clk_div_monitor #(.CNT_W(8), .EXP_HALF(EXP_HALF), .TOL(0), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT))
        u0 (.clk(clk), .rst(rst), .mon(if0));
    clk_div_monitor #(.CNT_W(8), .EXP_HALF(EXP_HALF), .TOL(1), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT))
        u1 (.clk(clk), .rst(rst), .mon(if1));

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            phase[k] = P_SEARCH;
            match[k] = 0;
            ecnt[k]  = 0;
            half[k]  = 0;
        end
    endtask

    task automatic bump_err(input int k);
        if (ecnt[k] < 255) ecnt[k]++;
    endtask

    task automatic push_ev(input int k, input ev_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference: each call describes one div_in edge arriving n cycles after the previous one.
    task automatic model_edge(input int k, input int n);
        ev_t e;
        int  d;
        if (n > TIMEOUT && phase[k] != P_SEARCH) begin
            phase[k] = P_SEARCH;
            match[k] = 0;
            bump_err(k);
            e.pv = 1'b0; e.half = 8'(half[k]); e.locked = 1'b0;
            e.err = 1'b1; e.ecnt = 8'(ecnt[k]); e.stuck = 1'b1;
            push_ev(k, e);
        end
        if (phase[k] == P_SEARCH) begin
            phase[k] = P_MEASURE;
            match[k] = 0;
        end else begin
            half[k] = (n > 255) ? 255 : n;
            d = half[k] - EXP_HALF;
            if (d < 0) d = -d;
            e.err = 1'b0;
            if (d <= tol[k]) begin
                if (phase[k] == P_MEASURE) begin
                    match[k]++;
                    if (match[k] == LOCK_COUNT) phase[k] = P_LOCKED;
                end
            end else begin
                phase[k] = P_MEASURE;
                match[k] = 0;
                bump_err(k);
                e.err = 1'b1;
            end
            e.pv = 1'b1; e.half = 8'(half[k]); e.locked = (phase[k] == P_LOCKED);
            e.ecnt = 8'(ecnt[k]); e.stuck = 1'b0;
            push_ev(k, e);
        end
    endtask

    task automatic interval(input int n);
        model_edge(0, n);
        model_edge(1, n);
        while (cyc - last_edge < n) begin
            @(posedge clk);
            #1;
        end
        div_r = ~div_r;
        last_edge = cyc;
        if (div_r) n_rise++;
        else       n_fall++;
    endtask

    task automatic check_ev(input int k, input ev_t a);
        ev_t w;
        tests++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            failed++;
            $display("FAIL unexpected_event u%0d: got pv=%0b err=%0b half=%0d, required no output event",
                     k, a.pv, a.err, a.half);
            return;
        end
        if (k == 0) w = q0.pop_front();
        else        w = q1.pop_front();
        if (a !== w) begin
            failed++;
            $display("FAIL event u%0d @%0t: got pv=%0b half=%0d locked=%0b err=%0b ecnt=%0d stuck=%0b, required pv=%0b half=%0d locked=%0b err=%0b ecnt=%0d stuck=%0b",
                     k, $time, a.pv, a.half, a.locked, a.err, a.ecnt, a.stuck,
                     w.pv, w.half, w.locked, w.err, w.ecnt, w.stuck);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        check_val({nm, "_u0"}, int'({if0.rise_pulse, if0.fall_pulse, if0.half_period, if0.period_valid,
                                     if0.locked, if0.err, if0.stuck, if0.err_count}), 0);
        check_val({nm, "_u1"}, int'({if1.rise_pulse, if1.fall_pulse, if1.half_period, if1.period_valid,
                                     if1.locked, if1.err, if1.stuck, if1.err_count}), 0);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1 rst = 1'b1;
        div_r = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        last_edge = cyc;
        @(negedge clk);
        check_zero("reset_mid");
    endtask

    task automatic en_window(input int n);
        @(posedge clk);
        #1 en_r = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_val("en_low_locked_u0", int'(if0.locked), 0);
            check_val("en_low_locked_u1", int'(if1.locked), 0);
        end
        check_val("en_low_half_u0", int'(if0.half_period), half[0]);
        check_val("en_low_half_u1", int'(if1.half_period), half[1]);
        for (int k = 0; k < 2; k++) begin
            phase[k] = P_SEARCH;
            match[k] = 0;
        end
        @(posedge clk);
        #1 en_r = 1'b1;
        last_edge = cyc;
    endtask

    ev_t a0, a1;
    always @(negedge clk) begin
        a0 = {if0.period_valid, if0.half_period, if0.locked, if0.err, if0.err_count, if0.stuck};
        a1 = {if1.period_valid, if1.half_period, if1.locked, if1.err, if1.err_count, if1.stuck};
        if (if0.period_valid || if0.err) check_ev(0, a0);
        if (if1.period_valid || if1.err) check_ev(1, a1);
        if (if0.rise_pulse) m_rise++;
        if (if0.fall_pulse) m_fall++;
    end

    initial begin
        int r;
        tol[0] = 0;
        tol[1] = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        last_edge = cyc;
        @(negedge clk);
        check_zero("reset");

        repeat (9) interval(4);
        interval(5);
        repeat (5) interval(4);
        interval(4); interval(5); interval(3); interval(4); interval(6);
        repeat (5) interval(4);

        interval(20);
        @(posedge clk);
        @(negedge clk);
        check_val("stuck_cleared_u0", int'(if0.stuck), 0);
        repeat (6) interval(4);

        interval(16);
        repeat (5) interval(4);
        interval(17);
        repeat (6) interval(4);

        en_window(10);
        repeat (6) interval(4);
        interval(5);
        repeat (5) interval(4);
        rst_pulse();
        repeat (6) interval(4);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 62)      interval(4);
            else if (r < 76) interval(int'($urandom_range(3, 5)));
            else if (r < 86) interval(int'($urandom_range(1, 8)));
            else if (r < 91) interval(16);
            else if (r < 96) interval(int'($urandom_range(17, 22)));
            else if (r < 98) en_window(int'($urandom_range(2, 12)));
            else             rst_pulse();
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("leftover_events_u0", q0.size(), 0);
        check_val("leftover_events_u1", q1.size(), 0);
        check_val("rise_pulses", m_rise, n_rise);
        check_val("fall_pulses", m_fall, n_fall);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Checks a divided clock on the consuming side. It samples a divider output (div_in, synchronous to clk) and measures the interval between consecutive edges in clk cycles.
- Compares each interval against an expected half-period and asserts locked once the ratio is stable.
- Flags mismatches and stalls. Used as a bring-up and health checker on divided-clock outputs.

Parameters:
- CNT_W, 8, width of interval counter and half_period output
- EXP_HALF, 4, expected clk cycles between successive div_in edges (divide-by-8 toggle output)
- TOL, 0, allowed absolute deviation from EXP_HALF, inclusive
- LOCK_COUNT, 4, consecutive in-tolerance intervals required to assert locked (1..15)
- TIMEOUT, 16, clk cycles without a div_in edge that count as a stall (must be < 2**CNT_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  monitor enable; low forces SEARCH
- div_in  in  1  divided clock under test, synchronous to clk
- rise_pulse  out  1  one-cycle pulse on a detected 0->1 of div_in
- fall_pulse  out  1  one-cycle pulse on a detected 1->0 of div_in
- half_period  out  CNT_W  last measured edge-to-edge interval
- period_valid  out  1  one-cycle pulse when half_period updates
- locked  out  1  ratio stable
- err  out  1  one-cycle pulse on mismatch or stall while MEASURE/LOCKED
- stuck  out  1  level; high while in SEARCH due to timeout, cleared on next edge
- err_count  out  8  saturating count of err pulses, cleared only by rst

Behaviour:
- Reset (rst high at a clk edge): state=SEARCH, div_q=0, run_cnt=0, match_cnt=0. All outputs are 0, including half_period and err_count.
- Edge detect:
  - div_q is registered div_in. edge = div_in != div_q, evaluated combinationally in the cycle div_in changes.
  - rise_pulse and fall_pulse are registered, so they assert 1 cycle after that cycle.
- Interval counter:
  - On an edge cycle, run_cnt is set to 0; otherwise run_cnt+1, saturating at 2**CNT_W-1.
  - measured = run_cnt+1 (saturating) on an edge cycle. For div_in toggling every 4 clk cycles, measured=4.
- In-tolerance test: |measured - EXP_HALF| <= TOL, computed at CNT_W+1 bits to avoid wrap.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: the first edge moves to MEASURE, clears stuck, and produces no measurement. run_cnt still counts. No err is raised in SEARCH.
  - MEASURE: on each edge, half_period=measured and period_valid pulses (registered, 1 cycle after the edge cycle).
    - In tolerance: match_cnt+1. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 in the same registered update as that period_valid.
    - Out of tolerance: match_cnt=0 and err pulses.
  - LOCKED: on each edge, half_period updates and period_valid pulses.
    - Out of tolerance: err pulses, locked=0, match_cnt=0, go to MEASURE.
- Timeout: in MEASURE or LOCKED, when run_cnt reaches TIMEOUT-1 with no edge, go to SEARCH, locked=0, stuck=1, match_cnt=0, and err pulses once. In SEARCH, run_cnt saturates with no further err.
- err_count increments by 1 per err pulse and saturates at 255.
- en low:
  - Next state is SEARCH; run_cnt=0, match_cnt=0; locked, stuck, and pulse outputs are 0.
  - div_q keeps tracking div_in. half_period and err_count hold.
  - When en rises, operation restarts from SEARCH.
- Simultaneous events:
  - rst has priority over everything, then en low.
  - An edge in the same cycle run_cnt hits TIMEOUT-1 counts as an edge, not a timeout.
- Reset mid-operation returns to full reset values on the next clk edge, including err_count=0.

Test Plan:
- Good divide-by-8 (defaults): div_in toggles every 4 cycles from reset.
  - period_valid pulses every 4 cycles with half_period=4.
  - locked=1 on the 4th period_valid after the first edge.
  - err is never asserted; rise_pulse and fall_pulse alternate.
- Glitched interval: once locked, one interval of 5, then 4s.
  - At the 5-interval: err pulse, err_count=1, locked=0, half_period=5.
  - locked reasserts after 4 further intervals of 4.
- Tolerance: TOL=1, intervals 4,5,3,4 → locked after the 4th with no err. An interval of 6 → err pulse and locked drops.
- Stall: once locked, hold div_in constant.
  - 16 cycles after the last edge: err pulse, stuck=1, locked=0, err_count=1.
  - The next edge clears stuck with no period_valid.
  - The following edges relock after 4 good intervals.
- en low mid-lock for 10 cycles then high: locked=0 throughout, no err, half_period unchanged; relock takes first edge + 4 intervals.
- rst pulse while locked with err_count=3: next cycle all outputs are 0, including err_count, and state is SEARCH.
